// File: rtl/regfile.sv
// Three-port integer register file: two combinational read ports and one
// synchronous write port. Register 0 is hardwired to zero.
module regfile #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  input  logic [AWIDTH-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] regs [DEPTH];

  // Reset wins over a same-edge write; writes to r0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we3 && (wa3 != '0)) begin
      regs[wa3] <= wd3;
    end
  end

  // No bypass: reads see the committed array contents, and r0 is forced to zero
  // even before the first reset.
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, write enable, r0 discard,
// reset priority, read-during-write and a full write/read-back sweep.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int totalCount = 0;
  int badCount   = 0;

  regfile #(.WIDTH(32), .AWIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advances one rising edge and settles just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
    reset = r;
    we3   = we;
    wa3   = wa;
    wd3   = wd;
    tick();
    reset = 1'b0;
    we3   = 1'b0;
  endtask

  function automatic logic [31:0] sweepValue(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010001;
  endfunction

  initial begin
    reset = 1'b0;
    we3   = 1'b0;
    ra1   = '0;
    ra2   = '0;
    wa3   = '0;
    wd3   = '0;
    #2;
    checkOutput("r0_before_reset_rd1", rd1, 32'h0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checkOutput("reset_rd1", rd1, 32'h0);
      checkOutput("reset_rd2", rd2, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 5'd1, 32'hffffffff);
    ra1 = 5'd0;
    ra2 = 5'd1;
    #1;
    checkOutput("write_r1_rd2", rd2, 32'hffffffff);
    checkOutput("r0_rd1", rd1, 32'h0);

    applyStimulus(1'b0, 1'b0, 5'd1, 32'heeeeeeee);
    #1;
    checkOutput("we_off_r1", rd2, 32'hffffffff);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'hdddddddd);
    ra1 = 5'd0;
    ra2 = 5'd2;
    #1;
    checkOutput("write_r0_discard", rd1, 32'h0);
    checkOutput("unwritten_r2", rd2, 32'h0);

    applyStimulus(1'b1, 1'b1, 5'd31, 32'h12345678);
    ra1 = 5'd31;
    ra2 = 5'd1;
    #1;
    checkOutput("reset_beats_write", rd1, 32'h0);
    checkOutput("reset_clears_r1", rd2, 32'h0);

    applyStimulus(1'b0, 1'b1, 5'd31, 32'h12345678);
    ra1 = 5'd31;
    ra2 = 5'd31;
    #1;
    checkOutput("r31_rd1", rd1, 32'h12345678);
    checkOutput("r31_rd2", rd2, 32'h12345678);

    // Read during write: old value before the edge, new value right after.
    ra1 = 5'd5;
    we3 = 1'b1;
    wa3 = 5'd5;
    wd3 = 32'hcafef00d;
    #1;
    checkOutput("rdw_before_edge", rd1, 32'h0);
    tick();
    we3 = 1'b0;
    checkOutput("rdw_after_edge", rd1, 32'hcafef00d);

    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), sweepValue(i));
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'((i + 7) % 32);
      #1;
      checkOutput("sweep_rd1", rd1, (i == 0) ? 32'h0 : sweepValue(i));
      checkOutput("sweep_rd2", rd2, (((i + 7) % 32) == 0) ? 32'h0 : sweepValue((i + 7) % 32));
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Three-port integer register file for the CPU core datapath: two combinational read ports (operand fetch, rs/rt) and one synchronous write port (write-back). Holds 32 registers of 32 bits; register 0 is hardwired to zero. Sits between the decode stage, which supplies the read addresses, and the write-back stage, which supplies the write address, data and enable.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - WIDTH, 32, register data width in bits.
  - AWIDTH, 5, address width; depth is 2**AWIDTH (32 registers).
- Ports:
  - clk  input  1  clock; all state updates on its rising edge.
  - reset  input  1  synchronous active-high reset; clears all registers.
  - we3  input  1  write enable for write port 3.
  - ra1  input  AWIDTH  read address, port 1.
  - ra2  input  AWIDTH  read address, port 2.
  - wa3  input  AWIDTH  write address, port 3.
  - wd3  input  WIDTH  write data, port 3.
  - rd1  output  WIDTH  read data, port 1.
  - rd2  output  WIDTH  read data, port 2.

## Operation
- Storage: registers r0..r31, each WIDTH bits.
- Read:
  - rd1 = (ra1 == 0) ? 0 : r[ra1]; rd2 = (ra2 == 0) ? 0 : r[ra2].
  - Purely combinational, no clock involvement.
  - Both ports are independent; ra1 == ra2 is legal, and both outputs then show the same value.
- Write:
  - On a rising clk edge with we3 = 1 and reset = 0, r[wa3] <= wd3.
  - wa3 == 0: the write is discarded; r0 always reads 0.
  - we3 = 0: no register changes, whatever the values of wa3 and wd3.
- Reset:
  - On a rising clk edge with reset = 1, all registers become 0.
  - Reset has priority over a simultaneous write; that write is lost.
- Read during write: no internal bypass.
  - Before the write edge, the read ports show the old contents.
  - After the edge, combinational reads show the new value in the same cycle.
  - Forwarding is the pipeline's responsibility.
- X handling: inputs are sampled only on the clk edge; the outputs follow the addressed contents with no additional state.

## Timing
- Write latency: data is visible on rd1/rd2 immediately after the rising edge that commits it (zero-cycle read after write-edge).
- Read latency: combinational; rd changes within the same cycle as ra changes.
- Reset: takes effect at the first rising edge with reset high. Every register reads 0 from then until written.
- Before the first reset, contents are undefined, except rd for address 0, which is always 0.
- No handshake and no back-pressure; a write is accepted on every enabled edge.

## Test plan
- Reset, then read r0..r31 on both ports -> all rd1/rd2 = 32'h00000000.
- we3=1, wa3=1, wd3=32'hffffffff, edge; ra2=1 -> rd2 = 32'hffffffff; ra1=0 -> rd1 = 0.
- we3=0, wa3=1, wd3=32'heeeeeeee, edge -> rd2 (ra2=1) still 32'hffffffff.
- we3=1, wa3=0, wd3=32'hdddddddd, edge; ra1=0 -> rd1 = 0. Then ra2=2 -> rd2 = 0 (never written).
- Write 32'h12345678 to r31 with reset=1 on the same edge -> r31 reads 0. Repeat with reset=0 -> ra1=ra2=31 both read 32'h12345678.
- Write distinct values to all 31 writable registers, read back via both ports -> each matches, r0 = 0.
